// File: rtl/axi_checker_sequencer_pkg.sv
// Shared definitions for the AXI-Lite checker sequencer.
// Contents: target register offsets, control-word bit positions, the top-level
// FSM state type, and small helpers that map a state to its bus transaction.
package axi_checker_sequencer_pkg;

  // Target register map (byte offsets).
  localparam logic [7:0] RegReset     = 8'h00;
  localparam logic [7:0] RegCtrl      = 8'h04;
  localparam logic [7:0] RegPktSize   = 8'h08;
  localparam logic [7:0] RegRdyLimit  = 8'h0C;
  localparam logic [7:0] RegNrdyLimit = 8'h10;
  localparam logic [7:0] RegDataErr   = 8'h14;
  localparam logic [7:0] RegPktErr    = 8'h18;
  localparam logic [7:0] RegDataSpd   = 8'h1C;
  localparam logic [7:0] RegPktSpd    = 8'h20;

  // Control register bit positions.
  localparam int unsigned CtrlEnableBit  = 0;
  localparam int unsigned CtrlIgnDataBit = 1;
  localparam int unsigned CtrlIgnPktBit  = 2;

  typedef enum logic [3:0] {
    StIdle,
    StWrRstSet,
    StWrRstClr,
    StWrPsize,
    StWrRlim,
    StWrNrlim,
    StWrEn,
    StRun,
    StRdDerr,
    StRdPerr,
    StRdDspd,
    StRdPspd,
    StWrDis
  } state_e;

  // Every state except IDLE and RUN owns exactly one bus transaction.
  function automatic logic is_xact(state_e s);
    return (s != StIdle) && (s != StRun);
  endfunction

  function automatic logic is_write(state_e s);
    return s inside {StWrRstSet, StWrRstClr, StWrPsize, StWrRlim, StWrNrlim, StWrEn, StWrDis};
  endfunction

  function automatic logic [7:0] state_offset(state_e s);
    case (s)
      StWrRstSet, StWrRstClr: return RegReset;
      StWrPsize:              return RegPktSize;
      StWrRlim:               return RegRdyLimit;
      StWrNrlim:              return RegNrdyLimit;
      StWrEn, StWrDis:        return RegCtrl;
      StRdDerr:               return RegDataErr;
      StRdPerr:               return RegPktErr;
      StRdDspd:               return RegDataSpd;
      StRdPspd:               return RegPktSpd;
      default:                return 8'h00;
    endcase
  endfunction

  // Successor of a transaction state when no STOP is pending.
  function automatic state_e next_state(state_e s);
    case (s)
      StWrRstSet: return StWrRstClr;
      StWrRstClr: return StWrPsize;
      StWrPsize:  return StWrRlim;
      StWrRlim:   return StWrNrlim;
      StWrNrlim:  return StWrEn;
      StWrEn:     return StRun;
      StRdDerr:   return StRdPerr;
      StRdPerr:   return StRdDspd;
      StRdDspd:   return StRdPspd;
      StRdPspd:   return StRun;
      default:    return StIdle;
    endcase
  endfunction

endpackage

// File: rtl/axi_checker_sequencer_if.sv
// AXI-Lite bus bundle between the sequencer (master) and the checker (slave).
// Parameter ADDR_WIDTH sets the address width; data is fixed at 32 bits.
interface axi_checker_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_single_master.sv
// Single-transaction AXI-Lite master.
// Ports: i_clk/i_reset (sync, active-high); i_req pulse with i_we/i_addr/i_wdata
// launches one read or write; o_done pulses on the B or R handshake, with
// o_rdata/o_resp valid in that same cycle; m_axi is the AXI-Lite master port.
// A new i_req may arrive in the o_done cycle; it is never issued while busy.
module axil_single_master #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic [1:0]            o_resp,
  axi_checker_sequencer_if.master m_axi
);

  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_wr_pend;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_aw_hs = r_awvalid & m_axi.awready;
  assign w_w_hs  = r_wvalid & m_axi.wready;
  assign w_b_hs  = r_bready & m_axi.bvalid;
  assign w_ar_hs = r_arvalid & m_axi.arready;
  assign w_r_hs  = r_rready & m_axi.rvalid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_wr_pend <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (i_req) begin
      r_addr    <= i_addr;
      r_wdata   <= i_we ? i_wdata : 32'h0;
      r_awvalid <= i_we;
      r_wvalid  <= i_we;
      r_wr_pend <= i_we;
      r_bready  <= 1'b0;
      r_arvalid <= ~i_we;
      r_rready  <= 1'b0;
    end else begin
      if (w_aw_hs) r_awvalid <= 1'b0;
      if (w_w_hs)  r_wvalid  <= 1'b0;
      // BREADY rises only once both the address and data phases are finished.
      if (r_wr_pend && !r_bready && (!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
        r_bready <= 1'b1;
      end
      if (w_b_hs) begin
        r_bready  <= 1'b0;
        r_wr_pend <= 1'b0;
      end
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (w_r_hs) r_rready <= 1'b0;
    end
  end

  assign m_axi.awvalid = r_awvalid;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.bready  = r_bready;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.rready  = r_rready;

  assign o_done  = w_b_hs | w_r_hs;
  assign o_rdata = m_axi.rdata;
  assign o_resp  = r_bready ? m_axi.bresp : m_axi.rresp;

endmodule

// File: rtl/axi_checker_sequencer.sv
// Configures an AXI-Lite traffic checker, enables it, then polls its four
// status counters every POLL_PERIOD cycles until STOP disables it again.
// Ports: i_clk/i_reset (sync, active-high); i_start/i_stop pulses; i_cfg_* checker
// settings sampled on an accepted start; o_busy/o_running state flags; four
// 32-bit status outputs with o_status_valid pulse; sticky o_resp_error;
// m_axi AXI-Lite master port (handshakes owned by axil_single_master).
module axi_checker_sequencer
  import axi_checker_sequencer_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 250000000,
  parameter int unsigned ADDR_WIDTH  = 6
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [31:0] i_cfg_packet_size,
  input  logic [31:0] i_cfg_ready_limit,
  input  logic [31:0] i_cfg_not_ready_limit,
  input  logic        i_cfg_ignore_data_error,
  input  logic        i_cfg_ignore_packet_error,
  output logic        o_busy,
  output logic        o_running,
  output logic [31:0] o_data_error,
  output logic [31:0] o_packet_error,
  output logic [31:0] o_data_speed,
  output logic [31:0] o_packet_speed,
  output logic        o_status_valid,
  output logic        o_resp_error,
  axi_checker_sequencer_if.master m_axi
);

  localparam int unsigned TimerWidth = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;

  state_e                r_state, w_state_d;
  logic [TimerWidth-1:0] r_timer;
  logic                  r_stop, r_running, r_status_valid, r_resp_error;
  logic [31:0]           r_cfg_psize, r_cfg_rlim, r_cfg_nrlim;
  logic                  r_cfg_ign_data, r_cfg_ign_pkt;
  logic [31:0]           r_sh_derr, r_sh_perr, r_sh_dspd, r_sh_pspd;
  logic [31:0]           r_data_error, r_packet_error, r_data_speed, r_packet_speed;

  logic                  w_req, w_we, w_done, w_stop_req;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_wdata, w_rdata, w_ctrl;
  logic [1:0]            w_resp;

  // A STOP seen this cycle counts as pending, so a boundary in the same cycle honours it.
  assign w_stop_req = r_stop | i_stop;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start && !i_stop) w_state_d = StWrRstSet;
      end
      StRun: begin
        if (w_stop_req) w_state_d = StWrDis;
        else if (r_timer == TimerWidth'(POLL_PERIOD - 1)) w_state_d = StRdDerr;
      end
      default: begin
        if (w_done) begin
          if (r_state == StWrDis) w_state_d = StIdle;
          else if (w_stop_req)    w_state_d = StWrDis;
          else                    w_state_d = next_state(r_state);
        end
      end
    endcase
  end

  // The request is issued on the edge that enters a transaction state, so the
  // bus VALIDs line up with the first cycle of that state.
  always_comb begin
    w_ctrl                 = 32'h0;
    w_ctrl[CtrlEnableBit]  = 1'b1;
    w_ctrl[CtrlIgnDataBit] = r_cfg_ign_data;
    w_ctrl[CtrlIgnPktBit]  = r_cfg_ign_pkt;
    w_req   = is_xact(w_state_d) && (w_state_d != r_state);
    w_we    = is_write(w_state_d);
    w_addr  = ADDR_WIDTH'(state_offset(w_state_d));
    w_wdata = 32'h0;
    case (w_state_d)
      StWrRstSet: w_wdata = 32'h1;
      StWrPsize:  w_wdata = r_cfg_psize;
      StWrRlim:   w_wdata = r_cfg_rlim;
      StWrNrlim:  w_wdata = r_cfg_nrlim;
      StWrEn:     w_wdata = w_ctrl;
      default:    w_wdata = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_timer        <= '0;
      r_stop         <= 1'b0;
      r_running      <= 1'b0;
      r_status_valid <= 1'b0;
      r_resp_error   <= 1'b0;
      r_cfg_psize    <= '0;
      r_cfg_rlim     <= '0;
      r_cfg_nrlim    <= '0;
      r_cfg_ign_data <= 1'b0;
      r_cfg_ign_pkt  <= 1'b0;
      r_sh_derr      <= '0;
      r_sh_perr      <= '0;
      r_sh_dspd      <= '0;
      r_sh_pspd      <= '0;
      r_data_error   <= '0;
      r_packet_error <= '0;
      r_data_speed   <= '0;
      r_packet_speed <= '0;
    end else begin
      r_state        <= w_state_d;
      r_status_valid <= 1'b0;

      if (r_state == StIdle && w_state_d == StWrRstSet) begin
        r_cfg_psize    <= i_cfg_packet_size;
        r_cfg_rlim     <= i_cfg_ready_limit;
        r_cfg_nrlim    <= i_cfg_not_ready_limit;
        r_cfg_ign_data <= i_cfg_ignore_data_error;
        r_cfg_ign_pkt  <= i_cfg_ignore_packet_error;
        r_resp_error   <= 1'b0;
      end

      if (r_state != StIdle && i_stop) r_stop <= 1'b1;

      if (w_state_d == StRun && r_state != StRun) r_timer <= '0;
      else if (r_state == StRun)                  r_timer <= r_timer + TimerWidth'(1);

      if (w_done) begin
        if (w_resp != 2'b00) r_resp_error <= 1'b1;
        case (r_state)
          StRdDerr: r_sh_derr <= w_rdata;
          StRdPerr: r_sh_perr <= w_rdata;
          StRdDspd: r_sh_dspd <= w_rdata;
          StRdPspd: begin
            r_sh_pspd      <= w_rdata;
            r_data_error   <= r_sh_derr;
            r_packet_error <= r_sh_perr;
            r_data_speed   <= r_sh_dspd;
            r_packet_speed <= w_rdata;
            r_status_valid <= 1'b1;
          end
          StWrEn:   r_running <= 1'b1;
          StWrDis: begin
            r_running <= 1'b0;
            r_stop    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  axil_single_master #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_master (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_req  (w_req),
    .i_we   (w_we),
    .i_addr (w_addr),
    .i_wdata(w_wdata),
    .o_done (w_done),
    .o_rdata(w_rdata),
    .o_resp (w_resp),
    .m_axi  (m_axi)
  );

  assign o_busy         = (r_state != StIdle);
  assign o_running      = r_running;
  assign o_status_valid = r_status_valid;
  assign o_resp_error   = r_resp_error;
  assign o_data_error   = r_data_error;
  assign o_packet_error = r_packet_error;
  assign o_data_speed   = r_data_speed;
  assign o_packet_speed = r_packet_speed;

endmodule
